// File: rtl/midi_pkg.sv
// Shared MIDI event types, status nibbles and byte formatting helpers.
package midi_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF = 2'd0,
        EV_NOTE_ON  = 2'd1,
        EV_CTRL     = 2'd2,
        EV_ALL_OFF  = 2'd3
    } ev_type_e;

    localparam logic [3:0] ST_NOTE_OFF      = 4'h8;
    localparam logic [3:0] ST_NOTE_ON       = 4'h9;
    localparam logic [3:0] ST_CTRL          = 4'hB;
    localparam logic [7:0] CC_ALL_NOTES_OFF = 8'h7B;
    // Never a legal status byte, so the first event after reset always sends its status.
    localparam logic [7:0] STATUS_NONE      = 8'h00;

    typedef struct packed {
        ev_type_e   kind;
        logic [3:0] chan;
        logic [6:0] key;
        logic [6:0] val;
    } midi_event_t;

    // Channel-voice status byte for an event.
    function automatic logic [7:0] status_of(input midi_event_t ev);
        logic [3:0] nib;
        case (ev.kind)
            EV_NOTE_OFF: nib = ST_NOTE_OFF;
            EV_NOTE_ON:  nib = ST_NOTE_ON;
            default:     nib = ST_CTRL;
        endcase
        return {nib, ev.chan};
    endfunction

    // First data byte: key / controller number, or the all-notes-off controller.
    function automatic logic [7:0] data1_of(input midi_event_t ev);
        return (ev.kind == EV_ALL_OFF) ? CC_ALL_NOTES_OFF : {1'b0, ev.key};
    endfunction

    // Second data byte: velocity / controller value, zero for all-notes-off.
    function automatic logic [7:0] data2_of(input midi_event_t ev);
        return (ev.kind == EV_ALL_OFF) ? 8'h00 : {1'b0, ev.val};
    endfunction

endpackage

// File: rtl/midi_event_tx_uart.sv
// 8N1 UART transmitter; back-to-back frames with no idle gap.
module midi_uart_tx #(
    parameter int unsigned BIT_DIV = 1600
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg_N,
    input  logic [7:0] data_byte,
    input  logic       byte_valid,
    output logic       uart_ready,
    output logic       midi_tx,
    output logic       byte_sent
);

    localparam int unsigned DIV_W = 11;
    localparam int unsigned CNT_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_BIT = CNT_W'(9);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(8);

    logic             active, active_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [CNT_W-1:0] bit_q, bit_nxt;
    logic [7:0]       shift_q, shift_nxt;
    logic             tx_nxt;
    logic             last_nxt;
    logic             load;

    // Ready is high while idle and during the last stop-bit cycle, so a load
    // there starts the next start bit immediately.
    assign load = byte_valid && uart_ready;

    // Next-state for divider, bit counter, shifter and line level.
    always_comb begin
        active_nxt = active;
        div_nxt    = div_q;
        bit_nxt    = bit_q;
        shift_nxt  = shift_q;
        tx_nxt     = midi_tx;
        if (active && div_q != DIV_LAST) begin
            div_nxt = div_q + DIV_W'(1);
        end else if (active && bit_q != STOP_BIT) begin
            div_nxt = '0;
            bit_nxt = bit_q + CNT_W'(1);
            if (bit_q == LAST_DATA) begin
                tx_nxt = 1'b1;
            end else begin
                tx_nxt    = shift_q[0];
                shift_nxt = {1'b0, shift_q[7:1]};
            end
        end else if (load) begin
            active_nxt = 1'b1;
            div_nxt    = '0;
            bit_nxt    = '0;
            shift_nxt  = data_byte;
            tx_nxt     = 1'b0;
        end else begin
            active_nxt = 1'b0;
            div_nxt    = '0;
            bit_nxt    = '0;
            tx_nxt     = 1'b1;
        end
        last_nxt = active_nxt && (bit_nxt == STOP_BIT) && (div_nxt == DIV_LAST);
    end

    // Frame state and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            active     <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            midi_tx    <= 1'b1;
            uart_ready <= 1'b1;
            byte_sent  <= 1'b0;
        end else begin
            active     <= active_nxt;
            div_q      <= div_nxt;
            bit_q      <= bit_nxt;
            shift_q    <= shift_nxt;
            midi_tx    <= tx_nxt;
            uart_ready <= !active_nxt || last_nxt;
            byte_sent  <= last_nxt;
        end
    end

endmodule

// File: rtl/midi_event_tx.sv
// MIDI OUT: event FIFO, running-status formatter and 31250-baud serialiser.
module midi_event_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BAUD           = 31250,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned AW             = 3,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic          CLOCK_50,
    input  logic          reset_reg_N,
    input  logic          ev_valid,
    output logic          ev_ready,
    input  logic [1:0]    ev_type,
    input  logic [3:0]    ev_chan,
    input  logic [6:0]    ev_key,
    input  logic [6:0]    ev_val,
    output logic          midi_tx,
    output logic          busy,
    output logic          byte_sent,
    output logic [AW:0]   fifo_level
);

    localparam int unsigned BIT_DIV    = CLK_HZ / BAUD;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, STATUS, DATA1, DATA2, WAIT} state_e;

    state_e      state, state_nxt;
    midi_event_t mem [DEPTH];
    midi_event_t ev_in, ev_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]  status_q, d1_q, d2_q, last_status;
    logic        push, pop, commit;
    logic [7:0]  data_byte;
    logic        byte_valid, uart_ready;

    assign ev_in    = {ev_type, ev_chan, ev_key, ev_val};
    assign ev_ready = (fifo_level != FULL_LEVEL);
    assign push     = ev_valid && ev_ready;
    // The UART is still on the line during its final stop cycle, where ready is already high.
    assign busy     = (fifo_level != '0) || (state != IDLE) || !uart_ready || byte_sent;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= ev_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Formatter state, event register, formatted bytes and running status.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state       <= IDLE;
            ev_q        <= '0;
            status_q    <= STATUS_NONE;
            d1_q        <= '0;
            d2_q        <= '0;
            last_status <= STATUS_NONE;
        end else begin
            state <= state_nxt;
            if (pop) ev_q <= mem[rd_ptr];
            if (state == LOAD) begin
                status_q <= status_of(ev_q);
                d1_q     <= data1_of(ev_q);
                d2_q     <= data2_of(ev_q);
            end
            if (commit) last_status <= status_q;
        end
    end

    // Next-state and byte hand-off; each byte waits in its state for the UART.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        commit     = 1'b0;
        byte_valid = 1'b0;
        data_byte  = status_q;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (RUNNING_STATUS != 0 && status_of(ev_q) == last_status) begin
                    state_nxt = DATA1;
                end else begin
                    state_nxt = STATUS;
                end
            end
            STATUS: begin
                byte_valid = 1'b1;
                data_byte  = status_q;
                if (uart_ready) state_nxt = DATA1;
            end
            DATA1: begin
                byte_valid = 1'b1;
                data_byte  = d1_q;
                if (uart_ready) state_nxt = DATA2;
            end
            DATA2: begin
                byte_valid = 1'b1;
                data_byte  = d2_q;
                if (uart_ready) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            // WAIT is never entered; any stray encoding recovers to IDLE.
            default: state_nxt = IDLE;
        endcase
    end

    midi_uart_tx #(
        .BIT_DIV (BIT_DIV)
    ) u_uart (
        .CLOCK_50    (CLOCK_50),
        .reset_reg_N (reset_reg_N),
        .data_byte   (data_byte),
        .byte_valid  (byte_valid),
        .uart_ready  (uart_ready),
        .midi_tx     (midi_tx),
        .byte_sent   (byte_sent)
    );

endmodule

// File: tb/tb_midi_event_tx.sv
// Scoreboard bench: two DUTs (running status on/off) fed the same event stream.
module tb_midi_event_tx;

    localparam int unsigned CLK_HZ = 500000;
    localparam int unsigned BAUD   = 31250;
    localparam int unsigned BD     = CLK_HZ / BAUD;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;

    logic CLOCK_50    = 1'b0;
    logic reset_reg_N = 1'b0;
    logic ev_valid    = 1'b0;
    logic [1:0] ev_type = '0;
    logic [3:0] ev_chan = '0;
    logic [6:0] ev_key  = '0;
    logic [6:0] ev_val  = '0;
    logic [1:0] ev_ready, midi_tx, busy, byte_sent, valid_g;
    logic [AW:0] lvl0, lvl1;

    int checks = 0;
    int errors = 0;
    int bs0 = 0;
    int bs1 = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] model_last = 8'h00;

    always #5 CLOCK_50 = ~CLOCK_50;

    // Both DUTs accept only when both are ready, so they see identical streams.
    assign valid_g[0] = ev_valid & ev_ready[1];
    assign valid_g[1] = ev_valid & ev_ready[0];

    midi_event_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .AW(AW), .RUNNING_STATUS(1)) u_rs (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .ev_valid(valid_g[0]), .ev_ready(ev_ready[0]),
        .ev_type(ev_type), .ev_chan(ev_chan), .ev_key(ev_key), .ev_val(ev_val),
        .midi_tx(midi_tx[0]), .busy(busy[0]), .byte_sent(byte_sent[0]), .fifo_level(lvl0));

    midi_event_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .AW(AW), .RUNNING_STATUS(0)) u_nrs (
        .CLOCK_50(CLOCK_50), .reset_reg_N(reset_reg_N), .ev_valid(valid_g[1]), .ev_ready(ev_ready[1]),
        .ev_type(ev_type), .ev_chan(ev_chan), .ev_key(ev_key), .ev_val(ev_val),
        .midi_tx(midi_tx[1]), .busy(busy[1]), .byte_sent(byte_sent[1]), .fifo_level(lvl1));

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: MIDI bytes an accepted event must produce on each line.
    task automatic model_push(input int t, input int c, input int k, input int v);
        logic [7:0] st, d1, d2;
        case (t)
            0:       st = 8'h80 + 8'(c);
            1:       st = 8'h90 + 8'(c);
            default: st = 8'hB0 + 8'(c);
        endcase
        d1 = (t == 3) ? 8'h7B : 8'(k);
        d2 = (t == 3) ? 8'h00 : 8'(v);
        if (st != model_last) exp0.push_back(st);
        exp0.push_back(d1);
        exp0.push_back(d2);
        exp1.push_back(st);
        exp1.push_back(d1);
        exp1.push_back(d2);
        model_last = st;
    endtask

    task automatic sb_compare(input int d, input logic [7:0] got);
        logic [7:0] want;
        if ((d == 0) ? (exp0.size() == 0) : (exp1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte dut%0d: actual %0h required none", d, got);
        end else begin
            want = (d == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("byte dut%0d", d), got, want);
        end
    endtask

    // Line monitors: decode frames by sampling bit centres.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int cnt = 0;
        int rx_cnt = 0;
        bit act = 1'b0;
        logic [7:0] sh = '0;
        always @(negedge CLOCK_50) begin
            if (!reset_reg_N) begin
                act = 1'b0;
            end else if (!act) begin
                if (midi_tx[g] == 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == BD / 2) begin
                    check($sformatf("start_bit dut%0d", g), int'(midi_tx[g]), 0);
                end else if (cnt > int'(BD) && cnt < int'(9 * BD) && (cnt % int'(BD)) == int'(BD / 2)) begin
                    sh = {midi_tx[g], sh[7:1]};
                end else if (cnt == int'(9 * BD + BD / 2)) begin
                    check($sformatf("stop_bit dut%0d", g), int'(midi_tx[g]), 1);
                    sb_compare(g, sh);
                    rx_cnt++;
                    act = 1'b0;
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (byte_sent[0]) bs0++;
        if (byte_sent[1]) bs1++;
    end

    task automatic send(input int t, input int c, input int k, input int v);
        int n;
        n = 0;
        ev_type  = 2'(t);
        ev_chan  = 4'(c);
        ev_key   = 7'(k);
        ev_val   = 7'(v);
        ev_valid = 1'b1;
        while (!(ev_ready[0] && ev_ready[1]) && n < 5000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual ev_ready %b required 11", ev_ready);
            ev_valid = 1'b0;
        end else begin
            @(posedge CLOCK_50);
            model_push(t, c, k, v);
            @(negedge CLOCK_50);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        ev_valid = 1'b0;
        while ((busy != 2'b00) && n < 40000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
        repeat (2) @(negedge CLOCK_50);
    endtask

    initial begin
        int n, b0;
        repeat (3) @(negedge CLOCK_50);
        reset_reg_N = 1'b1;
        @(negedge CLOCK_50);
        check("rst_midi_tx", int'(midi_tx[0]), 1);
        check("rst_ev_ready", int'(ev_ready[0]), 1);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_byte_sent", int'(byte_sent[0]), 0);
        check("rst_fifo_level", int'(lvl0), 0);

        // Single note-on: start-bit latency and total duration.
        b0 = bs0;
        send(1, 0, 60, 100);
        ev_valid = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("tx_before_start", int'(midi_tx[0]), 1);
        @(negedge CLOCK_50);
        check("tx_start_at_n3", int'(midi_tx[0]), 0);
        n = 4;
        while (busy[0] && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("busy_fall_cycle", n, int'(4 + 30 * BD));
        check("byte_sent_pulses", bs0 - b0, 3);
        wait_idle();

        // Running status, status changes, all-notes-off.
        send(1, 0, 60, 100);
        send(1, 0, 64, 90);
        wait_idle();
        send(1, 0, 60, 100);
        send(0, 0, 60, 0);
        send(0, 1, 60, 0);
        wait_idle();
        send(3, 2, $urandom_range(0, 127), $urandom_range(0, 127));
        send(2, 2, 7, 127);
        wait_idle();

        // Fill the FIFO: 9 accepted (one popped), then full.
        for (int i = 0; i < 9; i++) send($urandom_range(0, 3), 5, $urandom_range(0, 127), $urandom_range(0, 127));
        check("full_ev_ready", int'(ev_ready[0]), 0);
        check("full_level", int'(lvl0), 8);
        ev_valid = 1'b0;
        n = 0;
        while (!ev_ready[0] && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_after_pop", int'(ev_ready[0]), 1);
        check("level_after_pop", int'(lvl0), 7);
        for (int i = 0; i < 3; i++) send($urandom_range(0, 3), 5, $urandom_range(0, 127), $urandom_range(0, 127));
        wait_idle();

        // Reset during data bit 3 of a 0x90 status byte.
        send(0, 0, 1, 1);
        wait_idle();
        send(1, 0, 60, 100);
        send(2, 3, 10, 20);
        ev_valid = 1'b0;
        repeat (2 + 4 * BD + BD / 2) @(posedge CLOCK_50);
        #3;
        check("pre_reset_tx", int'(midi_tx[0]), 0);
        check("pre_reset_level", int'(lvl0), 1);
        reset_reg_N = 1'b0;
        #1;
        check("reset_tx_async", int'(midi_tx[0]), 1);
        check("reset_busy", int'(busy[0]), 0);
        check("reset_level", int'(lvl0), 0);
        exp0.delete();
        exp1.delete();
        model_last = 8'h00;
        repeat (2) @(negedge CLOCK_50);
        reset_reg_N = 1'b1;
        @(negedge CLOCK_50);
        send(1, 0, 60, 100);
        wait_idle();

        // Randomised traffic with small channel range to exercise running status.
        for (int i = 0; i < 30; i++) begin
            int gap;
            send($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 127), $urandom_range(0, 127));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                ev_valid = 1'b0;
                repeat (gap) @(negedge CLOCK_50);
            end
        end
        wait_idle();

        check("leftover_exp0", exp0.size(), 0);
        check("leftover_exp1", exp1.size(), 0);
        check("sent_vs_rx0", bs0, g_mon[0].rx_cnt);
        check("sent_vs_rx1", bs1, g_mon[1].rx_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
